// File: rtl/watch_mode_ctrl.sv
// Watch front-panel controller: maps debounced button events to the four-mode
// sequence and drives set-counter strobes, stopwatch control, FND select and edit blink.
module watch_mode_ctrl #(
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_HALF_MS   = 250
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_msec,
  input  logic [2:0] btn_pe,
  input  logic [2:0] btn_lvl,
  output logic [1:0] mode,
  output logic       capture_pe,
  output logic       load_pe,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       sw_run,
  output logic       sw_clear,
  output logic [1:0] disp_sel,
  output logic [3:0] blank_mask
);

  localparam int HOLD_W  = (REPEAT_DELAY_MS > 1) ? $clog2(REPEAT_DELAY_MS) : 1;
  localparam int TO_W    = (TIMEOUT_MS > 1)      ? $clog2(TIMEOUT_MS)      : 1;
  localparam int BLINK_W = (BLINK_HALF_MS > 1)   ? $clog2(BLINK_HALF_MS)   : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(REPEAT_DELAY_MS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TIMEOUT_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF_MS - 1);

  typedef enum logic [1:0] {
    ST_WATCH     = 2'd0,
    ST_SET_HR    = 2'd1,
    ST_SET_MIN   = 2'd2,
    ST_STOPWATCH = 2'd3
  } state_t;

  state_t state, state_n;

  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic               armed, armed_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
  logic               phase, phase_n;

  logic       capture_n, load_n, inc_hr_n, inc_min_n, sw_clear_n, sw_run_n;
  logic [1:0] disp_sel_n;
  logic [3:0] blank_mask_n;

  logic b0, b1, b2, in_set;
  logic set_n, rpt, to_fire, inc;
  logic lvl_unused;

  // Mode press masks the other two buttons in the same cycle.
  assign b0     = btn_pe[0];
  assign b1     = btn_pe[1] & ~b0;
  assign b2     = btn_pe[2] & ~b0;
  assign in_set = (state == ST_SET_HR) || (state == ST_SET_MIN);
  assign lvl_unused = btn_lvl[0] ^ btn_lvl[2];

  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    armed_n      = armed;
    to_cnt_n     = to_cnt;
    blink_cnt_n  = blink_cnt;
    phase_n      = phase;
    capture_n    = 1'b0;
    load_n       = 1'b0;
    inc_hr_n     = 1'b0;
    inc_min_n    = 1'b0;
    sw_clear_n   = 1'b0;
    sw_run_n     = sw_run;
    disp_sel_n   = 2'd0;
    blank_mask_n = 4'b0000;
    set_n        = 1'b0;
    rpt          = 1'b0;
    to_fire      = 1'b0;
    inc          = 1'b0;

    // Auto-repeat only follows a hold that was armed by a press in this mode.
    if (in_set && !b0 && !b2 && btn_lvl[1] && (armed || b1)) begin
      armed_n = 1'b1;
      if (b1) begin
        hold_cnt_n = '0;
      end else if (tick_msec) begin
        if (hold_cnt == HOLD_LAST) begin
          rpt        = 1'b1;
          hold_cnt_n = HOLD_RELOAD;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
    end else begin
      armed_n    = 1'b0;
      hold_cnt_n = '0;
    end

    if (!in_set || (|btn_pe) || rpt) begin
      to_cnt_n = '0;
    end else if (tick_msec) begin
      if (to_cnt == TO_LAST) begin
        to_fire  = 1'b1;
        to_cnt_n = '0;
      end else begin
        to_cnt_n = to_cnt + TO_W'(1);
      end
    end

    inc       = in_set & (b1 | rpt);
    inc_hr_n  = inc & (state == ST_SET_HR);
    inc_min_n = inc & (state == ST_SET_MIN);

    case (state)
      ST_WATCH: begin
        if (b0) begin
          state_n   = ST_SET_HR;
          capture_n = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (b0)                state_n = ST_SET_MIN;
        else if (b2 || to_fire) state_n = ST_WATCH;
      end
      ST_SET_MIN: begin
        if (b0) begin
          state_n = ST_STOPWATCH;
          load_n  = 1'b1;
        end else if (b2 || to_fire) begin
          state_n = ST_WATCH;
        end
      end
      default: begin
        if (b0) begin
          state_n = ST_WATCH;
        end else begin
          if (b2 && !sw_run) sw_clear_n = 1'b1;
          if (b1)            sw_run_n   = ~sw_run;
        end
      end
    endcase

    if (state_n != state) begin
      armed_n    = 1'b0;
      hold_cnt_n = '0;
      to_cnt_n   = '0;
    end

    // Digits stay visible on entry and right after every increment.
    set_n = (state_n == ST_SET_HR) || (state_n == ST_SET_MIN);
    if (!set_n || (state_n != state) || inc) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (tick_msec) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        blink_cnt_n = blink_cnt + BLINK_W'(1);
      end
    end

    case (state_n)
      ST_WATCH:     disp_sel_n = 2'd0;
      ST_STOPWATCH: disp_sel_n = 2'd2;
      default:      disp_sel_n = 2'd1;
    endcase

    if (phase_n && state_n == ST_SET_HR)  blank_mask_n = 4'b1100;
    if (phase_n && state_n == ST_SET_MIN) blank_mask_n = 4'b0011;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= ST_WATCH;
      hold_cnt   <= '0;
      armed      <= 1'b0;
      to_cnt     <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      capture_pe <= 1'b0;
      load_pe    <= 1'b0;
      inc_hr     <= 1'b0;
      inc_min    <= 1'b0;
      sw_run     <= 1'b0;
      sw_clear   <= 1'b0;
      disp_sel   <= 2'd0;
      blank_mask <= 4'b0000;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      armed      <= armed_n;
      to_cnt     <= to_cnt_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
      capture_pe <= capture_n;
      load_pe    <= load_n;
      inc_hr     <= inc_hr_n;
      inc_min    <= inc_min_n;
      sw_run     <= sw_run_n;
      sw_clear   <= sw_clear_n;
      disp_sel   <= disp_sel_n;
      blank_mask <= blank_mask_n;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed panel scenarios plus random button traffic,
// all checked cycle by cycle against a millisecond-level behavioural model.
module tb_watch_mode_ctrl;

  localparam int DLY  = 500;
  localparam int RATE = 100;
  localparam int TMO  = 10000;
  localparam int BLK  = 250;

  logic       clk;
  logic       reset_p;
  logic       tick_msec;
  logic [2:0] btn_pe;
  logic [2:0] btn_lvl;
  logic [1:0] mode;
  logic       capture_pe, load_pe, inc_hr, inc_min, sw_run, sw_clear;
  logic [1:0] disp_sel;
  logic [3:0] blank_mask;

  watch_mode_ctrl dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .tick_msec  (tick_msec),
    .btn_pe     (btn_pe),
    .btn_lvl    (btn_lvl),
    .mode       (mode),
    .capture_pe (capture_pe),
    .load_pe    (load_pe),
    .inc_hr     (inc_hr),
    .inc_min    (inc_min),
    .sw_run     (sw_run),
    .sw_clear   (sw_clear),
    .disp_sel   (disp_sel),
    .blank_mask (blank_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, in milliseconds and plain flags
  int m_mode, m_run, hold_ms, idle_ms, blink_ms;
  bit hold_on;
  int e_mode, e_cap, e_load, e_ihr, e_imin, e_run, e_clr, e_disp, e_mask;
  int cnt_cap, cnt_load, cnt_ihr, cnt_imin, cnt_clr;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; hold_ms = 0; idle_ms = 0; blink_ms = 0; hold_on = 0;
    e_mode = 0; e_cap = 0; e_load = 0; e_ihr = 0; e_imin = 0;
    e_run = 0; e_clr = 0; e_disp = 0; e_mask = 0;
  endtask

  task automatic model(input logic [2:0] pe, input logic [2:0] lvl, input logic tk);
    bit b0, b1, b2, setm, rpt, fire, inc;
    int nm;
    b0 = pe[0];
    b1 = pe[1] && !b0;
    b2 = pe[2] && !b0;
    setm = (m_mode == 1) || (m_mode == 2);
    e_cap = 0; e_load = 0; e_clr = 0;
    rpt = 0; fire = 0; nm = m_mode;

    if (setm && !b0 && !b2 && lvl[1] && (hold_on || b1)) begin
      hold_on = 1;
      if (b1) hold_ms = 0;
      else if (tk) begin
        hold_ms++;
        rpt = (hold_ms >= DLY) && ((hold_ms - DLY) % RATE == 0);
      end
    end else begin
      hold_on = 0;
      hold_ms = 0;
    end

    if (!setm || pe != 3'b000 || rpt) idle_ms = 0;
    else if (tk) begin
      idle_ms++;
      fire = (idle_ms == TMO);
    end

    inc    = setm && (b1 || rpt);
    e_ihr  = (inc && m_mode == 1) ? 1 : 0;
    e_imin = (inc && m_mode == 2) ? 1 : 0;

    case (m_mode)
      0: if (b0) begin nm = 1; e_cap = 1; end
      1: if (b0) nm = 2; else if (b2 || fire) nm = 0;
      2: if (b0) begin nm = 3; e_load = 1; end else if (b2 || fire) nm = 0;
      default: begin
        if (b0) nm = 0;
        else begin
          if (b2 && m_run == 0) e_clr = 1;
          if (b1) m_run = 1 - m_run;
        end
      end
    endcase

    if (nm != m_mode) begin
      hold_on = 0; hold_ms = 0; idle_ms = 0;
    end

    if (!(nm == 1 || nm == 2) || nm != m_mode || inc) blink_ms = 0;
    else if (tk) blink_ms++;

    e_mask = ((blink_ms / BLK) % 2 == 1) ? (nm == 1 ? 12 : (nm == 2 ? 3 : 0)) : 0;
    e_disp = (nm == 0) ? 0 : ((nm == 3) ? 2 : 1);
    m_mode = nm;
    e_mode = nm;
    e_run  = m_run;
  endtask

  task automatic step(input logic [2:0] pe, input logic [2:0] lvl, input logic tk);
    btn_pe = pe; btn_lvl = lvl; tick_msec = tk;
    model(pe, lvl, tk);
    @(posedge clk);
    #1;
    check_eq("mode",       int'(mode),       e_mode);
    check_eq("capture_pe", int'(capture_pe), e_cap);
    check_eq("load_pe",    int'(load_pe),    e_load);
    check_eq("inc_hr",     int'(inc_hr),     e_ihr);
    check_eq("inc_min",    int'(inc_min),    e_imin);
    check_eq("sw_run",     int'(sw_run),     e_run);
    check_eq("sw_clear",   int'(sw_clear),   e_clr);
    check_eq("disp_sel",   int'(disp_sel),   e_disp);
    check_eq("blank_mask", int'(blank_mask), e_mask);
    cnt_cap  += int'(capture_pe);
    cnt_load += int'(load_pe);
    cnt_ihr  += int'(inc_hr);
    cnt_imin += int'(inc_min);
    cnt_clr  += int'(sw_clear);
  endtask

  task automatic press(input int b);
    step(3'(1 << b), 3'(1 << b), 1'b0);
    step(3'b000, 3'b000, 1'b0);
  endtask

  task automatic idle(input int n, input logic [2:0] lvl);
    for (int i = 0; i < n; i++) step(3'b000, lvl, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mode"}, int'(mode), 0);
    check_eq({tag, "_pulses"}, int'({capture_pe, load_pe, inc_hr, inc_min, sw_clear}), 0);
    check_eq({tag, "_run"}, int'(sw_run), 0);
    check_eq({tag, "_disp"}, int'(disp_sel), 0);
    check_eq({tag, "_mask"}, int'(blank_mask), 0);
  endtask

  function automatic void clear_counts();
    cnt_cap = 0; cnt_load = 0; cnt_ihr = 0; cnt_imin = 0; cnt_clr = 0;
  endfunction

  logic [2:0] lv;
  logic [2:0] pe_r;
  int hold_left [3];

  initial begin
    reset_p = 1'b1; tick_msec = 1'b0; btn_pe = 3'b000; btn_lvl = 3'b000;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_p = 1'b0;

    // Full edit sequence ending in STOPWATCH
    press(0); press(1); press(1); press(1);
    press(0); press(1); press(1); press(0);
    check_eq("seq_capture", cnt_cap, 1);
    check_eq("seq_inc_hr", cnt_ihr, 3);
    check_eq("seq_inc_min", cnt_imin, 2);
    check_eq("seq_load", cnt_load, 1);
    check_eq("seq_mode", int'(mode), 3);
    check_eq("seq_disp", int'(disp_sel), 2);

    // Stopwatch run/clear and background running
    clear_counts();
    press(1); check_eq("sw_start", int'(sw_run), 1);
    press(2); check_eq("sw_clear_running", cnt_clr, 0);
    press(1); check_eq("sw_stop", int'(sw_run), 0);
    press(2); check_eq("sw_clear_stopped", cnt_clr, 1);
    press(1); press(0);
    check_eq("sw_bg_mode", int'(mode), 0);
    check_eq("sw_bg_run", int'(sw_run), 1);
    press(1); press(2);
    check_eq("watch_btn_run", int'(sw_run), 1);
    check_eq("watch_btn_clear", cnt_clr, 1);

    // Same-cycle mode+inc, and cancel without commit
    press(0);
    clear_counts();
    step(3'b011, 3'b011, 1'b0);
    check_eq("both_mode", int'(mode), 2);
    check_eq("both_inc_hr", int'(inc_hr), 0);
    step(3'b000, 3'b000, 1'b0);
    press(2); press(0); press(2);
    check_eq("cancel_mode", int'(mode), 0);
    check_eq("cancel_load", cnt_load, 0);

    // Blink in SET_HR
    press(0);
    idle(BLK - 1, 3'b000); check_eq("blink_0", int'(blank_mask), 0);
    idle(1, 3'b000);       check_eq("blink_1", int'(blank_mask), 12);
    idle(BLK - 1, 3'b000); check_eq("blink_2", int'(blank_mask), 12);
    idle(1, 3'b000);       check_eq("blink_3", int'(blank_mask), 0);
    press(2);

    // Held increment: press plus repeats at 500..1000 ms
    press(0);
    clear_counts();
    step(3'b010, 3'b010, 1'b0);
    idle(1000, 3'b010);
    step(3'b000, 3'b000, 1'b0);
    check_eq("hold_inc_hr", cnt_ihr, 7);
    press(2);

    // Hold carried from SET_HR into SET_MIN does not repeat
    press(0);
    step(3'b010, 3'b010, 1'b0);
    idle(200, 3'b010);
    clear_counts();
    step(3'b001, 3'b011, 1'b0);
    idle(700, 3'b010);
    step(3'b000, 3'b000, 1'b0);
    check_eq("cross_mode", int'(mode), 2);
    check_eq("cross_inc_min", cnt_imin, 0);
    press(2);

    // Edit timeout, restarted by a press at 9999 ms
    press(0); press(0);
    clear_counts();
    idle(TMO - 1, 3'b000); check_eq("to_9999a", int'(mode), 2);
    press(1);
    idle(TMO - 1, 3'b000); check_eq("to_9999b", int'(mode), 2);
    idle(1, 3'b000);       check_eq("to_fire", int'(mode), 0);
    check_eq("to_load", cnt_load, 0);

    // Reset in the middle of a hold in SET_MIN
    press(0); press(0);
    step(3'b010, 3'b010, 1'b0);
    idle(300, 3'b010);
    reset_p = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); @(posedge clk);
    #1;
    reset_p = 1'b0;
    model_reset();
    clear_counts();
    step(3'b001, 3'b011, 1'b0);
    idle(600, 3'b010);
    step(3'b000, 3'b000, 1'b0);
    check_eq("post_reset_inc", cnt_ihr, 0);
    press(2);

    // Random button traffic
    lv = 3'b000;
    for (int b = 0; b < 3; b++) hold_left[b] = 0;
    for (int c = 0; c < 15000; c++) begin
      pe_r = 3'b000;
      for (int b = 0; b < 3; b++) begin
        if (lv[b]) begin
          if (hold_left[b] == 0) lv[b] = 1'b0;
          else hold_left[b]--;
        end else if ($urandom_range(0, 299) == 0) begin
          pe_r[b] = 1'b1;
          lv[b] = 1'b1;
          hold_left[b] = (b == 1) ? int'($urandom_range(0, 1500)) : int'($urandom_range(0, 20));
        end
      end
      step(pe_r, lv, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
